// File: rtl/snd_flag_dcrm.sv
// -----------------------------------------------------------------------------
// snd_flag_dcrm
// Sound-CPU side glue logic with two parts:
//   * Latch-pending flag. A rising edge on the main CPU's latch strobe sets it,
//     and a sound-CPU read of the latch clears it. When enabled, the flag is
//     passed on to the sound CPU as an NMI request.
//   * DC remover. This is a first-order high-pass filter built from an
//     error-feedback integrator. It converts the unsigned PSG mix into a
//     signed sample with no DC component.
//
// Ports
//   clk     in   1    system clock
//   rst_n   in   1    asynchronous active-low reset
//   cen     in   1    sample enable for the DC remover
//   stb     in   1    latch strobe from main CPU (rising edge sets the flag)
//   clr     in   1    flag clear (sound CPU reads the latch)
//   nmi_en  in   1    NMI enable
//   flag_n  out  1    low while a latch write is pending
//   nmi_n   out  1    active-low NMI request = flag_n | ~nmi_en
//   din     in   SW   unsigned PSG sample
//   dout    out  SW   signed, DC-removed sample
// -----------------------------------------------------------------------------
module snd_flag_dcrm #(
    parameter int SW = 10,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          stb,
    input  logic          clr,
    input  logic          nmi_en,
    output logic          flag_n,
    output logic          nmi_n,
    input  logic [SW-1:0] din,
    output logic [SW-1:0] dout
);

    localparam int IW = SW + DW + 1;

    // Clamp the (SW+1)-bit difference into the SW-bit signed output range.
    function automatic logic signed [SW-1:0] sat_y(input logic signed [SW:0] v);
        if (v[SW] != v[SW-1])
            return v[SW] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        else
            return v[SW-1:0];
    endfunction

    // ---------------- latch-pending flag ----------------
    logic stb_l_q;
    logic pend_q, pend_d;
    logic stb_rise;

    assign stb_rise = stb & ~stb_l_q;

    // A clear takes priority over a simultaneous new edge.
    always_comb begin
        pend_d = pend_q;
        if (clr)
            pend_d = 1'b0;
        else if (stb_rise)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_l_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            stb_l_q <= stb;
            pend_q  <= pend_d;
        end
    end

    assign flag_n = ~pend_q;
    assign nmi_n  = flag_n | ~nmi_en;

    // ---------------- DC remover ----------------
    logic signed [IW-1:0] integ_q, integ_d;
    logic        [DW-1:0] err_q, err_d;
    logic signed [SW-1:0] dout_q, dout_d;

    logic signed [SW:0]   x;
    logic signed [IW-1:0] exact;
    logic signed [SW:0]   q;
    logic signed [SW:0]   y;

    always_comb begin
        x     = {1'b0, din};
        // The fractional residue from the previous sample is added back in.
        // This lets the integrator settle exactly on din<<DW with no offset.
        exact = integ_q + {{(SW+1){1'b0}}, err_q};
        q     = exact[IW-1:DW];
        y     = x - q;

        integ_d = integ_q;
        err_d   = err_q;
        dout_d  = dout_q;
        if (cen) begin
            integ_d = integ_q + {{DW{y[SW]}}, y};
            err_d   = exact[DW-1:0];
            dout_d  = sat_y(y);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q <= '0;
            err_q   <= '0;
            dout_q  <= '0;
        end else begin
            integ_q <= integ_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_snd_flag_dcrm.sv
// -----------------------------------------------------------------------------
// tb_snd_flag_dcrm
// Directed testbench for snd_flag_dcrm. It drives the flag and DC-remover
// inputs and compares the outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_snd_flag_dcrm;

    localparam int SW = 10;
    localparam int DW = 10;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic          stb;
    logic          clr;
    logic          nmi_en;
    logic          flag_n;
    logic          nmi_n;
    logic [SW-1:0] din;
    logic [SW-1:0] dout;

    int n_checks;
    int n_fail;

    snd_flag_dcrm #(.SW(SW), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .stb    (stb),
        .clr    (clr),
        .nmi_en (nmi_en),
        .flag_n (flag_n),
        .nmi_n  (nmi_n),
        .din    (din),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Step one clock. Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise cen for one clock, then hold it low for (gap-1) clocks.
    task automatic cen_pulse(input int gap);
        cen = 1'b1;
        tick();
        cen = 1'b0;
        repeat (gap - 1) tick();
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int sdout(input logic [SW-1:0] v);
        return int'($signed(v));
    endfunction

    int prev;
    int cur;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n  = 1'b0;
        cen    = 1'b0;
        stb    = 1'b0;
        clr    = 1'b0;
        nmi_en = 1'b0;
        din    = '0;

        // Reset state, observed while the reset is still asserted
        #3;
        check("rst_flag_n", int'(flag_n), 1);
        check("rst_nmi_n",  int'(nmi_n),  1);
        check("rst_dout",   sdout(dout),  0);
        #9;
        rst_n = 1'b1;
        tick();

        // din = 0 from reset: the output stays at zero
        for (int i = 0; i < 6; i++) begin
            cen_pulse(4);
            check($sformatf("zero_in_%0d", i), sdout(dout), 0);
        end

        // din = 512 from reset, cen every 4 clocks
        do_reset();
        din = 10'd512;
        cen_pulse(4);
        check("dc512_first_sat", sdout(dout), 511);
        repeat (16383) cen_pulse(4);
        cur = sdout(dout);
        check("dc512_settled_abs_le1", int'(cur >= -1 && cur <= 1), 1);

        // Settle at 300 (cen every clock), then step down to 200
        do_reset();
        din = 10'd300;
        cen = 1'b1;
        repeat (18000) tick();
        check("dc300_settled", sdout(dout), 0);
        din = 10'd200;
        tick();
        check("step_first", sdout(dout), -100);
        prev = sdout(dout);
        for (int i = 0; i < 8; i++) begin
            repeat (64) tick();
            cur = sdout(dout);
            check($sformatf("step_decay_%0d", i), int'(cur >= prev && cur <= 0), 1);
            prev = cur;
        end
        cen = 1'b0;
        din = '0;

        // Flag: a rising edge sets it; a clear while stb is held high does not retrigger
        do_reset();
        stb = 1'b1;
        tick();
        check("flag_set", int'(flag_n), 0);
        check("nmi_masked", int'(nmi_n), 1);
        nmi_en = 1'b1;
        #1;
        check("nmi_active", int'(nmi_n), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("flag_clr", int'(flag_n), 1);
        repeat (3) tick();
        check("flag_no_retrigger", int'(flag_n), 1);
        check("nmi_idle", int'(nmi_n), 1);

        // Rising edge and clear in the same cycle: clear wins
        stb = 1'b0;
        tick();
        stb = 1'b1;
        clr = 1'b1;
        tick();
        check("edge_and_clr", int'(flag_n), 1);
        clr = 1'b0;
        tick();
        check("edge_and_clr_after", int'(flag_n), 1);

        // Asynchronous reset mid-stream with the flag pending and dout non-zero
        stb = 1'b0;
        tick();
        stb = 1'b1;
        tick();
        check("pre_async_flag", int'(flag_n), 0);
        din = 10'd512;
        cen_pulse(1);
        check("pre_async_dout", sdout(dout), 511);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_flag_n", int'(flag_n), 1);
        check("async_dout",   sdout(dout),  0);
        check("async_nmi_n",  int'(nmi_n),  1);
        #2;
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
